// File: rtl/or_perceptron_trainer.sv
// ---------------------------------------------------------------------------
// or_perceptron_trainer
//   Trains a 2-input perceptron to reproduce the OR truth table. Each epoch
//   sweeps the samples (x1,x2) = 00,01,10,11. An internal or_gate provides
//   the target label. On a wrong prediction the weights and bias take one
//   saturating step of size LR toward the target. Training stops after the
//   first epoch with zero errors, or once MAX_EPOCH epochs have run.
//
//   Handshake: start is a single-cycle request. It is accepted only in IDLE
//   or DONE; while busy is high, start is ignored. done is a level that
//   stays high in DONE until the next accepted start or rst. converged
//   qualifies done.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               training request
//   w1_init, w2_init,   signed initial weights and bias, captured in LOAD
//   b_init
//   busy                high in LOAD/EVAL/UPDATE/EPOCH_END
//   done, converged     finished; converged=1 means a zero-error epoch
//   w1, w2, b           live signed weights and bias
//   epoch               current epoch index (0-based)
//   err_cnt             error count of the last completed epoch
//   dbg_state_o         FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module or_perceptron_trainer #(
   parameter int W         = 8,
   parameter int LR        = 1,
   parameter int MAX_EPOCH = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] w1_init,
   input  logic signed [W-1:0] w2_init,
   input  logic signed [W-1:0] b_init,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic signed [W-1:0] w1,
   output logic signed [W-1:0] w2,
   output logic signed [W-1:0] b,
   output logic [3:0]          epoch,
   output logic [2:0]          err_cnt,
   output logic [2:0]          dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_EVAL      = 3'd2,
      S_UPDATE    = 3'd3,
      S_EPOCH_END = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // Arithmetic is done two bits wider than the weights. The sum of three
   // W-bit signed terms always fits in that width, so it cannot overflow.
   localparam logic signed [W+1:0] LR_S = (W+2)'(LR);
   localparam logic signed [W+1:0] MAXV = (W+2)'((2 ** (W-1)) - 1);
   localparam logic signed [W+1:0] MINV = ~MAXV;

   function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
      if (v > MAXV)      return MAXV[W-1:0];
      else if (v < MINV) return MINV[W-1:0];
      else               return v[W-1:0];
   endfunction

   state_t              state_q, state_d;
   logic signed [W-1:0] w1_q, w1_d, w2_q, w2_d, b_q, b_d;
   logic [3:0]          epoch_q, epoch_d;
   logic [2:0]          err_q, err_d;
   logic [2:0]          run_q, run_d;       // errors in the epoch in progress
   logic [1:0]          idx_q, idx_d;       // sample index, bits = {x1,x2}
   logic                y_q, y_d, t_q, t_d;
   logic                done_q, done_d, conv_q, conv_d;

   logic                x1, x2, t_w, y_w;
   logic signed [W+1:0] w1_x, w2_x, b_x, sum, step;
   logic signed [W-1:0] w1_upd, w2_upd, b_upd;

   assign x1 = idx_q[1];
   assign x2 = idx_q[0];

   or_gate u_teacher (
      .a_i (x1),
      .b_i (x2),
      .y_o (t_w)
   );

   always_comb begin
      w1_x   = {{2{w1_q[W-1]}}, w1_q};
      w2_x   = {{2{w2_q[W-1]}}, w2_q};
      b_x    = {{2{b_q[W-1]}}, b_q};
      sum    = b_x + (x1 ? w1_x : '0) + (x2 ? w2_x : '0);
      y_w    = ~sum[W+1];
      // The error term d = t - y is +1 when the target is 1, and -1 otherwise.
      step   = t_q ? LR_S : -LR_S;
      w1_upd = sat(w1_x + step);
      w2_upd = sat(w2_x + step);
      b_upd  = sat(b_x + step);
   end

   always_comb begin
      state_d = state_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      b_d     = b_q;
      epoch_d = epoch_q;
      err_d   = err_q;
      run_d   = run_q;
      idx_d   = idx_q;
      y_d     = y_q;
      t_d     = t_q;
      done_d  = done_q;
      conv_d  = conv_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               done_d  = 1'b0;
               conv_d  = 1'b0;
               run_d   = '0;
               epoch_d = '0;
               idx_d   = '0;
            end
         end
         S_LOAD: begin
            w1_d    = w1_init;
            w2_d    = w2_init;
            b_d     = b_init;
            state_d = S_EVAL;
         end
         S_EVAL: begin
            y_d     = y_w;
            t_d     = t_w;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            if (y_q != t_q) begin
               if (x1) w1_d = w1_upd;
               if (x2) w2_d = w2_upd;
               b_d   = b_upd;
               run_d = run_q + 3'd1;
            end
            if (idx_q == 2'd3) begin
               state_d = S_EPOCH_END;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_EVAL;
            end
         end
         S_EPOCH_END: begin
            err_d = run_q;
            run_d = '0;
            if (run_q == 3'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               conv_d  = 1'b1;
            end else if (epoch_q == 4'(MAX_EPOCH - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               conv_d  = 1'b0;
            end else begin
               epoch_d = epoch_q + 4'd1;
               idx_d   = '0;
               state_d = S_EVAL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         w1_q    <= '0;
         w2_q    <= '0;
         b_q     <= '0;
         epoch_q <= '0;
         err_q   <= '0;
         run_q   <= '0;
         idx_q   <= '0;
         y_q     <= 1'b0;
         t_q     <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         b_q     <= b_d;
         epoch_q <= epoch_d;
         err_q   <= err_d;
         run_q   <= run_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         t_q     <= t_d;
         done_q  <= done_d;
         conv_q  <= conv_d;
      end
   end

   assign busy        = (state_q == S_LOAD) || (state_q == S_EVAL) ||
                        (state_q == S_UPDATE) || (state_q == S_EPOCH_END);
   assign done        = done_q;
   assign converged   = conv_q;
   assign w1          = w1_q;
   assign w2          = w2_q;
   assign b           = b_q;
   assign epoch       = epoch_q;
   assign err_cnt     = err_q;
   assign dbg_state_o = state_q;

endmodule

// ---------------------------------------------------------------------------
// or_gate
//   The teacher: returns the OR of two bits.
// Ports
//   a_i, b_i   inputs
//   y_o        a_i | b_i
// ---------------------------------------------------------------------------
module or_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i | b_i;
endmodule

// File: tb/tb_or_perceptron_trainer.sv
module tb_or_perceptron_trainer;
   localparam int W    = 8;
   localparam int LR   = 1;
   localparam int MAX0 = 15;
   localparam int MAX1 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start;
   logic signed [W-1:0] w1_init, w2_init, b_init;

   logic busy0, done0, conv0, busy1, done1, conv1;
   logic signed [W-1:0] w1_0, w2_0, b_0, w1_1, w2_1, b_1;
   logic [3:0] epoch0, epoch1;
   logic [2:0] err0, err1, st0, st1;

   or_perceptron_trainer #(.W(W), .LR(LR), .MAX_EPOCH(MAX0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start),
      .w1_init(w1_init), .w2_init(w2_init), .b_init(b_init),
      .busy(busy0), .done(done0), .converged(conv0),
      .w1(w1_0), .w2(w2_0), .b(b_0), .epoch(epoch0), .err_cnt(err0),
      .dbg_state_o(st0)
   );

   or_perceptron_trainer #(.W(W), .LR(LR), .MAX_EPOCH(MAX1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start),
      .w1_init(w1_init), .w2_init(w2_init), .b_init(b_init),
      .busy(busy1), .done(done1), .converged(conv1),
      .w1(w1_1), .w2(w2_1), .b(b_1), .epoch(epoch1), .err_cnt(err1),
      .dbg_state_o(st1)
   );

   // Snapshot of all observable outputs after one clock edge.
   typedef struct packed {
      logic       busy;
      logic       done;
      logic       conv;
      logic [7:0] w1;
      logic [7:0] w2;
      logic [7:0] b;
      logic [3:0] epoch;
      logic [2:0] err;
   } snap_t;

   snap_t q0[$];
   snap_t q1[$];
   snap_t hold0 = '0;
   snap_t hold1 = '0;
   int    n_vec = 0;
   int    n_err = 0;
   bit    chk_en = 1'b0;

   // ---------------- reference model ----------------
   function automatic int clamp(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic push(input int inst, input snap_t s);
      if (inst == 0) q0.push_back(s);
      else           q1.push_back(s);
   endtask

   // Generates the expected snapshot for each edge of one training run. The
   // first snapshot is for the edge that accepts start; the last is for the
   // edge that enters DONE.
   task automatic build(input int inst, input int mx, input snap_t prev,
                        input int a1, input int a2, input int ab);
      int    w1v, w2v, bv, ep, errs, x1, x2, y, t, d;
      bit    fin;
      snap_t s;
      w1v = a1; w2v = a2; bv = ab;
      s = prev;
      s.busy = 1'b1; s.done = 1'b0; s.conv = 1'b0; s.epoch = 4'd0;
      push(inst, s);                                   // LOAD
      s.w1 = 8'(w1v); s.w2 = 8'(w2v); s.b = 8'(bv);
      push(inst, s);                                   // first EVAL
      ep = 0; fin = 1'b0;
      while (!fin) begin
         errs = 0;
         for (int smp = 0; smp < 4; smp++) begin
            push(inst, s);                             // update cycle
            x1 = smp / 2;
            x2 = smp % 2;
            y  = (bv + x1 * w1v + x2 * w2v >= 0) ? 1 : 0;
            t  = (x1 != 0 || x2 != 0) ? 1 : 0;
            if (y != t) begin
               d   = t - y;
               w1v = clamp(w1v + LR * d * x1);
               w2v = clamp(w2v + LR * d * x2);
               bv  = clamp(bv + LR * d);
               errs++;
            end
            s.w1 = 8'(w1v); s.w2 = 8'(w2v); s.b = 8'(bv);
            push(inst, s);                             // next EVAL or epoch end
         end
         s.err = 3'(errs);
         if (errs == 0 || ep == mx - 1) begin
            s.busy = 1'b0; s.done = 1'b1; s.conv = (errs == 0);
            fin = 1'b1;
         end else begin
            ep++;
         end
         s.epoch = 4'(ep);
         push(inst, s);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q0.delete(); q1.delete();
         hold0 = '0; hold1 = '0;
      end else if (start) begin
         if (q0.size() == 0) build(0, MAX0, hold0, int'(w1_init), int'(w2_init), int'(b_init));
         if (q1.size() == 0) build(1, MAX1, hold1, int'(w1_init), int'(w2_init), int'(b_init));
      end
   end

   // ---------------- scoreboard compare ----------------
   task automatic check_snap(input string nm, input snap_t act, input snap_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got busy=%0d done=%0d conv=%0d w1=%0d w2=%0d b=%0d ep=%0d err=%0d expected busy=%0d done=%0d conv=%0d w1=%0d w2=%0d b=%0d ep=%0d err=%0d",
                  nm, $time, act.busy, act.done, act.conv, $signed(act.w1), $signed(act.w2),
                  $signed(act.b), act.epoch, act.err, exp.busy, exp.done, exp.conv,
                  $signed(exp.w1), $signed(exp.w2), $signed(exp.b), exp.epoch, exp.err);
      end
   endtask

   always @(negedge clk) begin
      snap_t a0, a1, e0, e1;
      if (chk_en) begin
         a0 = {busy0, done0, conv0, w1_0, w2_0, b_0, epoch0, err0};
         a1 = {busy1, done1, conv1, w1_1, w2_1, b_1, epoch1, err1};
         if (q0.size() > 0) begin e0 = q0.pop_front(); hold0 = e0; end else e0 = hold0;
         if (q1.size() > 0) begin e1 = q1.pop_front(); hold1 = e1; end else e1 = hold1;
         check_snap("cycle_dut0", a0, e0);
         check_snap("cycle_dut1", a1, e1);
      end
   end

   // ---------------- literal checks and drivers ----------------
   task automatic lit(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Pulses start with the given inits, then waits for dut0 done. e0/e1 are
   // the edges, counted from the accepting edge as 0, at which done rose.
   task automatic run(input int a1, input int a2, input int ab, input int pulse_k,
                      output int e0, output int e1);
      @(negedge clk);
      w1_init = 8'(a1); w2_init = 8'(a2); b_init = 8'(ab);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = -1; e1 = -1;
      lit("load_done_low", int'(done0), 0);
      for (int k = 1; k <= 400 && e0 < 0; k++) begin
         start = (k == pulse_k);
         @(negedge clk);
         if (done1 && e1 < 0) e1 = k;
         if (done0) e0 = k;
      end
      start = 1'b0;
      if (e0 < 0) begin
         n_vec++; n_err++;
         $display("FAIL run_timeout got no done expected done within 400 edges");
      end
   endtask

   task automatic pin_t1(input string tag, input int e0);
      lit({tag, "_done_edge"}, e0, 37);
      lit({tag, "_conv"}, int'(conv0), 1);
      lit({tag, "_epoch"}, int'(epoch0), 3);
      lit({tag, "_err"}, int'(err0), 0);
      lit({tag, "_w1"}, int'(w1_0), 1);
      lit({tag, "_w2"}, int'(w2_0), 1);
      lit({tag, "_b"}, int'(b_0), -1);
   endtask

   initial begin
      int e0, e1;
      rst = 1'b1; start = 1'b0;
      w1_init = '0; w2_init = '0; b_init = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      lit("rst_busy", int'(busy0), 0);
      lit("rst_done", int'(done0), 0);
      lit("rst_w1", int'(w1_0), 0);
      rst = 1'b0;

      // Baseline from zero weights; the MAX_EPOCH=2 instance stops early.
      run(0, 0, 0, -1, e0, e1);
      pin_t1("t1", e0);
      lit("t2_done_edge", e1, 19);
      lit("t2_conv", int'(conv1), 0);
      lit("t2_epoch", int'(epoch1), 1);
      lit("t2_err", int'(err1), 2);
      lit("t2_w1", int'(w1_1), 1);
      lit("t2_w2", int'(w2_1), 1);
      lit("t2_b", int'(b_1), 0);

      // Restart from DONE with start pulsed mid-run: the pulse must be ignored.
      run(0, 0, 0, 5, e0, e1);
      pin_t1("t6", e0);

      // Weights already solve OR: one clean epoch.
      run(1, 1, -1, -1, e0, e1);
      lit("t4_done_edge", e0, 10);
      lit("t4_conv", int'(conv0), 1);
      lit("t4_epoch", int'(epoch0), 0);
      lit("t4_w1", int'(w1_0), 1);
      lit("t4_b", int'(b_0), -1);

      // Saturation: w2 is pushed past +127 and must clamp.
      run(127, 127, -128, -1, e0, e1);
      lit("sat_done_edge", e0, 19);
      lit("sat_conv", int'(conv0), 1);
      lit("sat_epoch", int'(epoch0), 1);
      lit("sat_w2", int'(w2_0), 127);
      lit("sat_b", int'(b_0), -127);

      // Reset during epoch 1, then a fresh run must match the baseline.
      @(negedge clk);
      w1_init = '0; w2_init = '0; b_init = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lit("t5_busy", int'(busy0), 0);
      lit("t5_done", int'(done0), 0);
      lit("t5_w2", int'(w2_0), 0);
      lit("t5_b", int'(b_0), 0);
      lit("t5_epoch", int'(epoch0), 0);
      lit("t5_err", int'(err0), 0);
      run(0, 0, 0, -1, e0, e1);
      pin_t1("t5rerun", e0);

      // Random phase: random starts (some while busy), rare resets. Inits
      // change only alongside a start and hold for the following LOAD cycle.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         if (!start && $urandom_range(0, 29) == 0) begin
            start = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
               w1_init = 8'(int'($urandom_range(0, 8)) - 4);
               w2_init = 8'(int'($urandom_range(0, 8)) - 4);
               b_init  = 8'(int'($urandom_range(0, 8)) - 4);
            end else begin
               w1_init = 8'($urandom_range(0, 255));
               w2_init = 8'($urandom_range(0, 255));
               b_init  = 8'($urandom_range(0, 255));
            end
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
